// File: rtl/lsu_stall_ctrl.sv
// Load/store sequencer for the E->MW pipeline register: runs the req/gnt/rvalid handshake and stalls until it completes.
// Optional access timeout is compiled in with `define LSU_TIMEOUT_EN.
module lsu_stall_ctrl #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_op_E,
  input  logic              mem_we_E,
  input  logic              kill_E,
  output logic              dmem_req,
  output logic              dmem_we,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic              dmem_err,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_MW,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   ld_data_q, ld_data_d;
  logic                timeout;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    err_d     = err_q;
    ld_data_d = ld_data_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_op_E && !kill_E) begin
          state_d = REQ;
          we_d    = mem_we_E;
          err_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
`ifdef LSU_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (kill_E && !dmem_gnt) begin
          state_d = IDLE;
        end else if (dmem_gnt && we_q) begin
          state_d = DONE;
          err_d   = dmem_err;
        end else if (dmem_gnt && dmem_rvalid) begin
          state_d   = DONE;
          err_d     = dmem_err;
          ld_data_d = dmem_err ? '0 : dmem_rdata;
        end else if (timeout) begin
          // A grant without data on the last allowed cycle still counts as incomplete
          state_d = DONE;
          err_d   = 1'b1;
          if (!we_q) ld_data_d = '0;
        end else if (dmem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
`ifdef LSU_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (dmem_rvalid) begin
          state_d   = DONE;
          err_d     = dmem_err;
          ld_data_d = dmem_err ? '0 : dmem_rdata;
        end else if (timeout) begin
          state_d   = DONE;
          err_d     = 1'b1;
          ld_data_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      ld_data_q <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // The entry term holds the register during the cycle the access is first seen
  assign stall_MW = ((state_q == IDLE) && mem_op_E && !kill_E) ||
                    (state_q == REQ) || (state_q == WAIT);
  assign dmem_req = (state_q == REQ);
  assign dmem_we  = (state_q == REQ) && we_q;
  assign ld_valid = (state_q == DONE) && !we_q && !err_q;
  assign bus_err  = (state_q == DONE) && err_q;
  assign ld_data  = ld_data_q;

endmodule
